// File: rtl/clkmeas.sv
// ---------------------------------------------------------------------------
// clkmeas: frequency meter for an asynchronous clock returning from off-chip.
// meas_in is synchronised into clk, and its rising edges are counted over a
// programmable window of clk cycles. A window with no edges flags the input
// as stuck high or stuck low. Results are reported through a start/done
// handshake.
//
// Optional feature (macro CLKMEAS_PERIOD_MINMAX_EN): the minimum and maximum
// edge-to-edge period seen in the window. When the macro is undefined,
// per_min/per_max are constants and no period logic is built.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth on meas_in (legal range 2..4)
// Ports:
//   clk       system clock, posedge
//   rst_n     asynchronous active-low reset
//   meas_in   asynchronous clock under measurement (max useful rate clk/2)
//   start     one-cycle request to begin a measurement (ignored while busy)
//   win_len   window length in clk cycles, sampled on accepted start (0 -> 1)
//   busy      measurement window in progress
//   done      one-cycle pulse; results valid from this cycle onward
//   edge_cnt  rising edges counted in the last window
//   stuck_hi  last window saw no edges and meas_in was high at window end
//   stuck_lo  last window saw no edges and meas_in was low at window end
//   per_min   minimum edge-to-edge period in clk cycles (0xFFFF if < 2 edges)
//   per_max   maximum edge-to-edge period in clk cycles (0 if < 2 edges)
// ---------------------------------------------------------------------------
module clkmeas #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        meas_in,
  input  logic        start,
  input  logic [15:0] win_len,
  output logic        busy,
  output logic        done,
  output logic [15:0] edge_cnt,
  output logic        stuck_hi,
  output logic        stuck_lo,
  output logic [15:0] per_min,
  output logic [15:0] per_max
);

  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Synchroniser chain plus one delay flop for edge detection
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_dly_q;
  logic                   s_last;
  logic                   rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      s_dly_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], meas_in};
      s_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_last = sync_q[SYNC_STAGES-1];
  assign rise   = s_last & ~s_dly_q;

  // Control state and working counters
  state_e        state_q, state_d;
  logic [CW-1:0] win_q, win_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] ecnt_q, ecnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] edge_cnt_q, edge_cnt_d;
  logic          stuck_hi_q, stuck_hi_d;
  logic          stuck_lo_q, stuck_lo_d;
  logic          load_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      win_q      <= CW'(1);
      wcnt_q     <= '0;
      ecnt_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      edge_cnt_q <= '0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      wcnt_q     <= wcnt_d;
      ecnt_q     <= ecnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      edge_cnt_q <= edge_cnt_d;
      stuck_hi_q <= stuck_hi_d;
      stuck_lo_q <= stuck_lo_d;
    end
  end

  // Next-state, window/edge counting and result capture
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    wcnt_d     = wcnt_q;
    ecnt_d     = ecnt_q;
    load_res   = 1'b0;
    edge_cnt_d = edge_cnt_q;
    stuck_hi_d = stuck_hi_q;
    stuck_lo_d = stuck_lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          win_d   = (win_len == '0) ? CW'(1) : win_len;
          wcnt_d  = CW'(1);
          ecnt_d  = '0;
          state_d = ST_MEAS;
        end
      end
      ST_MEAS: begin
        if (rise) begin
          ecnt_d = ecnt_q + CW'(1);
        end
        if (wcnt_q == win_q) begin
          load_res = 1'b1;
          state_d  = ST_DONE;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Results capture the count including the last window cycle's edge
    if (load_res) begin
      edge_cnt_d = ecnt_d;
      stuck_hi_d = (ecnt_d == '0) &  s_last;
      stuck_lo_d = (ecnt_d == '0) & ~s_last;
    end

    busy_d = (state_d == ST_MEAS);
    done_d = (state_d == ST_DONE);
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign edge_cnt = edge_cnt_q;
  assign stuck_hi = stuck_hi_q;
  assign stuck_lo = stuck_lo_q;

`ifdef CLKMEAS_PERIOD_MINMAX_EN
  // Edge-to-edge period tracking within the window
  logic [CW-1:0] per_cnt_q, per_cnt_d;
  logic [CW-1:0] min_q, min_d;
  logic [CW-1:0] max_q, max_d;
  logic          seen_q, seen_d;
  logic [CW-1:0] per_min_q, per_min_d;
  logic [CW-1:0] per_max_q, per_max_d;
  logic [CW-1:0] period_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q <= '0;
      min_q     <= '1;
      max_q     <= '0;
      seen_q    <= 1'b0;
      per_min_q <= '1;
      per_max_q <= '0;
    end else begin
      per_cnt_q <= per_cnt_d;
      min_q     <= min_d;
      max_q     <= max_d;
      seen_q    <= seen_d;
      per_min_q <= per_min_d;
      per_max_q <= per_max_d;
    end
  end

  always_comb begin
    per_cnt_d = per_cnt_q;
    min_d     = min_q;
    max_d     = max_q;
    seen_d    = seen_q;
    per_min_d = per_min_q;
    per_max_d = per_max_q;
    // Saturating increment; also the period length ending at this rise
    period_c  = (per_cnt_q == '1) ? '1 : per_cnt_q + CW'(1);

    if ((state_q == ST_IDLE) && start) begin
      per_cnt_d = '0;
      min_d     = '1;
      max_d     = '0;
      seen_d    = 1'b0;
    end else if (state_q == ST_MEAS) begin
      if (rise) begin
        per_cnt_d = '0;
        seen_d    = 1'b1;
        // The first rise only starts the period counter
        if (seen_q) begin
          if (period_c < min_q) begin
            min_d = period_c;
          end
          if (period_c > max_q) begin
            max_d = period_c;
          end
        end
      end else begin
        per_cnt_d = period_c;
      end
    end

    if (load_res) begin
      per_min_d = min_d;
      per_max_d = max_d;
    end
  end

  assign per_min = per_min_q;
  assign per_max = per_max_q;
`else
  assign per_min = '1;
  assign per_max = '0;
`endif

endmodule

// File: tb/tb_clkmeas.sv
// ---------------------------------------------------------------------------
// tb_clkmeas: self-checking bench for clkmeas. meas_in is driven from a
// repeating bit pattern synchronous to clk; expected results are queued when
// a measurement starts and compared when the DUT pulses done.
// ---------------------------------------------------------------------------
module tb_clkmeas;

`ifdef CLKMEAS_PERIOD_MINMAX_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        meas_in;
  logic        start;
  logic [15:0] win_len;
  logic        busy;
  logic        done;
  logic [15:0] edge_cnt;
  logic        stuck_hi;
  logic        stuck_lo;
  logic [15:0] per_min;
  logic [15:0] per_max;

  clkmeas #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .meas_in  (meas_in),
    .start    (start),
    .win_len  (win_len),
    .busy     (busy),
    .done     (done),
    .edge_cnt (edge_cnt),
    .stuck_hi (stuck_hi),
    .stuck_lo (stuck_lo),
    .per_min  (per_min),
    .per_max  (per_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int win;
    int cnt_lo;
    int cnt_hi;
    bit chk_stuck;
    bit s_hi;
    bit s_lo;
    int pmin;
    int pmax;
  } vec_t;

  vec_t q[$];
  vec_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int pm(input int v);
    return PER_EN ? v : 32'hFFFF;
  endfunction

  function automatic int px(input int v);
    return PER_EN ? v : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Repeating meas_in pattern, index 0 first
  logic [7:0] pat_bits;
  int         pat_len;
  int         pat_idx;

  initial begin
    pat_bits = 8'd0;
    pat_len  = 1;
    pat_idx  = 0;
    meas_in  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pat_idx >= pat_len) pat_idx = 0;
      meas_in = pat_bits[pat_idx];
      pat_idx = pat_idx + 1;
      if (pat_idx >= pat_len) pat_idx = 0;
    end
  end

  // 0: low, 1: high, 2: clk/2, 3: clk/4, 4: clk/3, 5: periods 3 and 5 alternating
  task automatic set_mode(input int mode);
    case (mode)
      0: begin pat_bits = 8'b0000_0000; pat_len = 1; end
      1: begin pat_bits = 8'b0000_0001; pat_len = 1; end
      2: begin pat_bits = 8'b0000_0010; pat_len = 2; end
      3: begin pat_bits = 8'b0000_1100; pat_len = 4; end
      4: begin pat_bits = 8'b0000_0001; pat_len = 3; end
      default: begin pat_bits = 8'b0000_1001; pat_len = 8; end
    endcase
  endtask

  // Start is high for exactly one cycle (cycle T); returns inside cycle T+1
  task automatic do_start(input logic [15:0] w);
    @(posedge clk);
    #1;
    win_len = w;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", q.size(), 0);
  endtask

  task automatic run_vec(input vec_t v);
    set_mode(v.mode);
    repeat (10) @(posedge clk);
    q.push_back(v);
    do_start(16'(v.win));
    drain(v.win + 20);
  endtask

  // Scoreboard monitor: compare each done against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, expected no done");
      end else begin
        mon_e = q.pop_front();
        check_rng("edge_cnt", int'(edge_cnt), mon_e.cnt_lo, mon_e.cnt_hi);
        if (mon_e.chk_stuck) begin
          check("stuck_hi", int'(stuck_hi), int'(mon_e.s_hi));
          check("stuck_lo", int'(stuck_lo), int'(mon_e.s_lo));
        end
        check("per_min", int'(per_min), mon_e.pmin);
        check("per_max", int'(per_max), mon_e.pmax);
      end
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[8];
  vec_t v;
  int   n_done;

  initial begin
    tbl[0] = '{0, 100,   0,     0,     1'b1, 1'b0, 1'b1, 32'hFFFF, 0};
    tbl[1] = '{1, 50,    0,     0,     1'b1, 1'b1, 1'b0, 32'hFFFF, 0};
    tbl[2] = '{3, 400,   100,   100,   1'b1, 1'b0, 1'b0, pm(4), px(4)};
    tbl[3] = '{4, 300,   100,   100,   1'b1, 1'b0, 1'b0, pm(3), px(3)};
    tbl[4] = '{5, 800,   200,   200,   1'b1, 1'b0, 1'b0, pm(3), px(5)};
    tbl[5] = '{2, 0,     0,     1,     1'b0, 1'b0, 1'b0, 32'hFFFF, 0};
    tbl[6] = '{2, 65535, 32767, 32768, 1'b1, 1'b0, 1'b0, pm(2), px(2)};
    tbl[7] = '{3, 401,   100,   101,   1'b1, 1'b0, 1'b0, pm(4), px(4)};

    rst_n   = 1'b0;
    start   = 1'b0;
    win_len = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_edge_cnt", int'(edge_cnt), 0);
    check("rst_stuck_hi", int'(stuck_hi), 0);
    check("rst_stuck_lo", int'(stuck_lo), 0);
    check("rst_per_min", int'(per_min), 32'hFFFF);
    check("rst_per_max", int'(per_max), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i]);
    end

    // Window timing: busy over T+1..T+100, done only at T+101
    set_mode(0);
    repeat (10) @(posedge clk);
    v = '{0, 100, 0, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF, 0};
    q.push_back(v);
    do_start(16'd100);
    n_done = 0;
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      if (done) n_done++;
      if (k == 1)   check("t_busy_first", int'(busy), 1);
      if (k == 100) check("t_busy_last", int'(busy), 1);
      if (k == 100) check("t_done_early", int'(done), 0);
      if (k == 101) check("t_done_pulse", int'(done), 1);
      if (k == 101) check("t_busy_at_done", int'(busy), 0);
      if (k == 102) check("t_done_width", int'(done), 0);
      @(posedge clk);
    end
    check("t_done_count", n_done, 1);
    drain(10);

    // win_len = 0 behaves as a one-cycle window: done at T+2
    q.push_back(v);
    do_start(16'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) check("w0_busy", int'(busy), 1);
      if (k == 1) check("w0_no_done", int'(done), 0);
      if (k == 2) check("w0_done", int'(done), 1);
      @(posedge clk);
    end
    drain(10);

    // Start while busy is ignored; results hold until the next done
    set_mode(3);
    repeat (10) @(posedge clk);
    v = '{3, 100, 25, 25, 1'b1, 1'b0, 1'b0, pm(4), px(4)};
    q.push_back(v);
    do_start(16'd100);
    n_done = 0;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      if (done) n_done++;
      if (k == 11)  check("sb_busy_kept", int'(busy), 1);
      if (k == 101) check("sb_done_at_101", int'(done), 1);
      if (k == 130) check("sb_retained", int'(edge_cnt), 25);
      @(posedge clk);
      #1;
      start   = (k == 9);
      win_len = 16'd7;
    end
    start = 1'b0;
    check("sb_done_count", n_done, 1);
    v = '{3, 200, 50, 50, 1'b1, 1'b0, 1'b0, pm(4), px(4)};
    q.push_back(v);
    do_start(16'd200);
    @(negedge clk);
    check("sb_not_cleared", int'(edge_cnt), 25);
    drain(220);

    // Reset mid-window: immediate reset values, no done pulse afterwards
    v = '{3, 100, 25, 25, 1'b1, 1'b0, 1'b0, pm(4), px(4)};
    q.push_back(v);
    do_start(16'd100);
    repeat (29) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("mr_busy", int'(busy), 0);
    check("mr_edge_cnt", int'(edge_cnt), 0);
    check("mr_done", int'(done), 0);
    check("mr_per_min", int'(per_min), 32'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("mr_no_done", n_done, 0);
    v = '{3, 400, 100, 100, 1'b1, 1'b0, 1'b0, pm(4), px(4)};
    run_vec(v);

    // meas_in high across reset release: spurious rise is masked in IDLE
    set_mode(1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    v = '{1, 50, 0, 0, 1'b1, 1'b1, 1'b0, 32'hFFFF, 0};
    q.push_back(v);
    do_start(16'd50);
    drain(70);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
